// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308-style ADC controller.
// Glyphs are active-low seven-segment patterns in {g,f,e,d,c,b,a} order.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, WAIT} state_t;

  localparam int CFG_BITS = 6;
  localparam int RES_BITS = 12;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic logic [6:0] seg_glyph(input logic [3:0] n);
    logic [6:0] s;
    s = SEG_0;
    case (n)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/adc_if.sv
// SPI-style pin bundle between the controller (master) and the ADC chip (slave).
interface adc_if;
  logic ADC_SCLK;
  logic ADC_DIN;
  logic ADC_DOUT;
  logic ADC_CONVST;

  modport master (output ADC_SCLK, output ADC_DIN, output ADC_CONVST, input ADC_DOUT);
  modport slave  (input ADC_SCLK, input ADC_DIN, input ADC_CONVST, output ADC_DOUT);
endinterface

// File: rtl/adc_ctrl_hex7seg.sv
// Hex nibble to active-low seven-segment decoder.
module hex7seg
  import adc_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = seg_glyph(i_nib);
endmodule

// File: rtl/adc_ctrl.sv
// Free-running LTC2308 frame controller: CONVST pulse, 12-bit SPI exchange, then idle
// until the frame counter wraps. Result is shown on LEDR, HEX4..HEX2 and GPIO.
module adc_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int T_CONV_CYCLES = 80,
  parameter int FRAME_CYCLES  = 200
)(
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [15:0] GPIO,
  adc_if.master       adc
);

  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int CW = $clog2(T_CONV_CYCLES + CLK_DIV);
  localparam logic [FW-1:0] FRM_LAST  = FW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(T_CONV_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(RES_BITS - 1);

  logic w_rst;
  logic w_unused;
  logic [CFG_BITS-1:0] w_cfg_sw;

  // Declaration values match the reset values so the block runs without KEY[0].
  state_t              r_state  = IDLE;
  logic [FW-1:0]       r_frm    = '0;
  logic [CW-1:0]       r_cnt    = '0;
  logic [3:0]          r_bit    = '0;
  logic [CFG_BITS-1:0] r_cfg    = '0;
  logic [RES_BITS-1:0] r_shr    = '0;
  logic [RES_BITS-1:0] r_res    = '0;
  logic                r_sclk   = 1'b0;
  logic                r_din    = 1'b0;
  logic                r_convst = 1'b0;

  state_t              w_state;
  logic [FW-1:0]       w_frm;
  logic [CW-1:0]       w_cnt;
  logic [3:0]          w_bit;
  logic [CFG_BITS-1:0] w_cfg;
  logic [RES_BITS-1:0] w_shr;
  logic [RES_BITS-1:0] w_res;
  logic                w_sclk;
  logic                w_din;
  logic                w_convst;

  assign w_rst    = KEY[0];
  assign w_unused = ^{KEY[3:2], SW[9:3]};
  // {single-ended, O/S, S1, S0, unipolar, no-sleep}
  assign w_cfg_sw = {1'b1, SW[2:0], 1'b1, 1'b0};

  always_ff @(posedge CLOCK_50 or posedge w_rst) begin
    if (w_rst) begin
      r_state  <= IDLE;
      r_frm    <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_cfg    <= '0;
      r_shr    <= '0;
      r_res    <= '0;
      r_sclk   <= 1'b0;
      r_din    <= 1'b0;
      r_convst <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_frm    <= w_frm;
      r_cnt    <= w_cnt;
      r_bit    <= w_bit;
      r_cfg    <= w_cfg;
      r_shr    <= w_shr;
      r_res    <= w_res;
      r_sclk   <= w_sclk;
      r_din    <= w_din;
      r_convst <= w_convst;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_frm    = (r_frm == FRM_LAST) ? '0 : r_frm + 1'b1;
    w_cnt    = r_cnt;
    w_bit    = r_bit;
    w_cfg    = r_cfg;
    w_shr    = r_shr;
    w_res    = r_res;
    w_sclk   = r_sclk;
    w_din    = r_din;
    w_convst = r_convst;
    case (r_state)
      IDLE: begin
        w_state  = CONV;
        w_cfg    = w_cfg_sw;
        w_convst = 1'b1;
        w_cnt    = '0;
      end
      CONV: begin
        if (r_cnt == CONV_LAST) begin
          w_state  = SHIFT;
          w_convst = 1'b0;
          w_cnt    = '0;
          w_bit    = '0;
          w_sclk   = 1'b0;
          w_din    = r_cfg[CFG_BITS-1];
          w_cfg    = {r_cfg[CFG_BITS-2:0], 1'b0};
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      SHIFT: begin
        w_cnt = r_cnt + 1'b1;
        if (r_cnt == HALF_LAST) begin
          w_sclk = 1'b1;
          w_shr  = {r_shr[RES_BITS-2:0], adc.ADC_DOUT};
        end else if (r_cnt == DIV_LAST) begin
          w_cnt  = '0;
          w_sclk = 1'b0;
          if (r_bit == BIT_LAST) begin
            w_state = WAIT;
            w_din   = 1'b0;
            if (!KEY[1]) w_res = r_shr;
          end else begin
            // cfg drains to zero after six shifts, so DIN idles low for bits 6..11
            w_bit = r_bit + 1'b1;
            w_din = r_cfg[CFG_BITS-1];
            w_cfg = {r_cfg[CFG_BITS-2:0], 1'b0};
          end
        end
      end
      WAIT: begin
        if (r_frm == '0) begin
          w_state  = CONV;
          w_cfg    = w_cfg_sw;
          w_convst = 1'b1;
          w_cnt    = '0;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign adc.ADC_SCLK   = r_sclk;
  assign adc.ADC_DIN    = r_din;
  assign adc.ADC_CONVST = r_convst;

  assign LEDR = r_res[RES_BITS-1:2];
  assign GPIO = {r_res, adc.ADC_DOUT, r_din, r_convst, r_sclk};

  hex7seg u_hex5 (.i_nib({1'b0, SW[2:0]}), .o_seg(HEX5));
  hex7seg u_hex4 (.i_nib(r_res[11:8]),     .o_seg(HEX4));
  hex7seg u_hex3 (.i_nib(r_res[7:4]),      .o_seg(HEX3));
  hex7seg u_hex2 (.i_nib(r_res[3:0]),      .o_seg(HEX2));

endmodule

// File: tb/tb_adc_ctrl.sv
// Bench for adc_ctrl: ADC chip model, frame monitor, vector table, corner sequences, random frames.
module tb_adc_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic [3:0]  KEY      = 4'h0;
  logic [9:0]  SW       = 10'h0CC;
  logic [9:0]  LEDR;
  logic [6:0]  HEX5, HEX4, HEX3, HEX2;
  logic [15:0] GPIO;

  adc_if adc();

  adc_ctrl dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .LEDR     (LEDR),
    .HEX5     (HEX5),
    .HEX4     (HEX4),
    .HEX3     (HEX3),
    .HEX2     (HEX2),
    .GPIO     (GPIO),
    .adc      (adc)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;

  // ADC chip model: MSB presented at CONVST, next bit after each SCLK fall.
  logic [11:0] next_word = 12'h000;
  logic [11:0] cur_word  = 12'h000;
  int          bidx      = 0;
  logic        adc_dout  = 1'b0;
  assign adc.ADC_DOUT = adc_dout;

  always @(posedge adc.ADC_CONVST) begin
    cur_word = next_word;
    bidx     = 0;
    adc_dout = cur_word[11];
  end

  always @(negedge adc.ADC_SCLK) begin
    if (bidx < 11) begin
      bidx     = bidx + 1;
      adc_dout = cur_word[11 - bidx];
    end
  end

  // Frame monitor, sampled on the falling clock edge.
  int          cyc = 0, nrise = 0, last_rise = 0, prev_rise = 0;
  int          conv_hi = 0, conv_len = 0;
  int          n_sclk = 0, sclk_hi = 0, first_sr = 0, last_sr = 0;
  logic [11:0] din_bits = '0;
  logic        p_conv = 1'b0, p_sclk = 1'b0;

  always @(negedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (adc.ADC_CONVST && !p_conv) begin
      nrise     <= nrise + 1;
      prev_rise <= last_rise;
      last_rise <= cyc + 1;
      conv_hi   <= 1;
      n_sclk    <= 0;
      sclk_hi   <= 0;
      din_bits  <= '0;
    end else begin
      if (adc.ADC_CONVST) conv_hi <= conv_hi + 1;
      if (adc.ADC_SCLK) begin
        sclk_hi <= sclk_hi + 1;
        if (!p_sclk) begin
          n_sclk   <= n_sclk + 1;
          din_bits <= {din_bits[10:0], adc.ADC_DIN};
          if (n_sclk == 0) first_sr <= cyc + 1;
          last_sr  <= cyc + 1;
        end
      end
    end
    if (!adc.ADC_CONVST && p_conv) conv_len <= conv_hi;
    p_conv <= adc.ADC_CONVST;
    p_sclk <= adc.ADC_SCLK;
  end

  function automatic logic [6:0] g(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [11:0] exp_din(input logic [2:0] s);
    return {1'b1, s, 1'b1, 1'b0, 6'b000000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic wait_rise();
    int k0 = nrise;
    int n = 0;
    while (nrise == k0 && n < 400) begin tick(); n++; end
    chk("convst_rise_seen", 32'(nrise != k0), 1);
  endtask

  task automatic wait_conv_fall();
    int n = 0;
    while (adc.ADC_CONVST && n < 200) begin tick(); n++; end
    chk("convst_fall_seen", 32'(adc.ADC_CONVST), 0);
  endtask

  task automatic wait_shift_done();
    int n = 0;
    while (n_sclk < 12 && n < 300) begin tick(); n++; end
    chk("sclk_12_seen", 32'(n_sclk >= 12), 1);
    repeat (3) tick();
  endtask

  task automatic frame_checks(input logic [11:0] din_exp, input bit per);
    chk("convst_len", conv_len, 80);
    chk("sclk_pulses", n_sclk, 12);
    chk("sclk_span", last_sr - first_sr, 44);
    chk("sclk_high_cycles", sclk_hi, 24);
    chk("din_bits", din_bits, din_exp);
    if (per) chk("frame_period", last_rise - prev_rise, 200);
  endtask

  task automatic check_outputs(input logic [11:0] r, input logic [2:0] s);
    chk("ledr", LEDR, r[11:2]);
    chk("gpio_res", GPIO[15:4], r);
    chk("hex4", HEX4, g(r[11:8]));
    chk("hex3", HEX3, g(r[7:4]));
    chk("hex2", HEX2, g(r[3:0]));
    chk("hex5", HEX5, g({1'b0, s}));
    chk("gpio_ctl_idle", GPIO[2:0], 0);
  endtask

  typedef struct {
    logic [9:0]  sw;
    logic [11:0] word;
    logic        key1;
    logic [9:0]  ledr;
    logic [6:0]  h4, h3, h2, h5;
    logic [11:0] din;
  } vec_t;

  vec_t        tv [6];
  logic [11:0] prev_res = 12'h000;

  initial begin
    logic [11:0] w1, w2, word, expv;
    logic [9:0]  sw;
    logic        k1;
    int          rel_cyc;

    tv[0] = '{10'h0CC, 12'h000, 1'b0, 10'h000, 7'h40, 7'h40, 7'h40, 7'h19, 12'hC80};
    tv[1] = '{10'h0CC, 12'hA5C, 1'b0, 10'h297, 7'h08, 7'h12, 7'h46, 7'h19, 12'hC80};
    tv[2] = '{10'h0CB, 12'h123, 1'b1, 10'h297, 7'h08, 7'h12, 7'h46, 7'h30, 12'hB80};
    tv[3] = '{10'h0CB, 12'h123, 1'b0, 10'h048, 7'h79, 7'h24, 7'h30, 7'h30, 12'hB80};
    tv[4] = '{10'h007, 12'hFFF, 1'b0, 10'h3FF, 7'h0E, 7'h0E, 7'h0E, 7'h78, 12'hF80};
    tv[5] = '{10'h000, 12'h800, 1'b0, 10'h200, 7'h00, 7'h40, 7'h40, 7'h40, 12'h880};

    // power-up state before the first clock edge, KEY[0] never asserted
    #5;
    chk("pu_ledr", LEDR, 0);
    chk("pu_convst", adc.ADC_CONVST, 0);
    chk("pu_sclk", adc.ADC_SCLK, 0);
    chk("pu_din", adc.ADC_DIN, 0);
    chk("pu_hex4", HEX4, 7'h40);
    chk("pu_hex2", HEX2, 7'h40);
    chk("pu_gpio_res", GPIO[15:4], 0);

    for (int i = 0; i < 6; i++) begin
      SW = tv[i].sw;
      KEY[1] = tv[i].key1;
      next_word = tv[i].word;
      wait_rise();
      if (i == 0) chk("first_convst_cycle", last_rise, 1);
      wait_shift_done();
      if (i == 0) chk("first_frame_5us", 32'(cyc < 250), 1);
      frame_checks(tv[i].din, i > 0);
      chk("tv_ledr", LEDR, tv[i].ledr);
      chk("tv_hex4", HEX4, tv[i].h4);
      chk("tv_hex3", HEX3, tv[i].h3);
      chk("tv_hex2", HEX2, tv[i].h2);
      chk("tv_hex5", HEX5, tv[i].h5);
      prev_res = tv[i].key1 ? prev_res : tv[i].word;
      chk("tv_gpio_res", GPIO[15:4], prev_res);
    end

    // SW change mid-SHIFT: HEX5 follows at once, cfg only at the next frame
    SW = 10'h004;
    KEY[1] = 1'b0;
    w1 = 12'($urandom_range(0, 4095));
    next_word = w1;
    wait_rise();
    wait_conv_fall();
    repeat (9) tick();
    SW = 10'h003;
    #1;
    chk("midshift_hex5", HEX5, 7'h30);
    wait_shift_done();
    frame_checks(12'hC80, 1);
    check_outputs(w1, 3'd3);
    w2 = 12'h800 | 12'($urandom_range(0, 2047));
    next_word = w2;
    wait_rise();
    wait_shift_done();
    frame_checks(12'hB80, 1);
    check_outputs(w2, 3'd3);

    // async reset pulse mid-SHIFT, taken during an SCLK high phase
    SW = 10'h007;
    next_word = 12'h5A5;
    wait_rise();
    wait_conv_fall();
    repeat (10) tick();
    chk("pre_rst_sclk", adc.ADC_SCLK, 1);
    chk("pre_rst_din", adc.ADC_DIN, 1);
    #3 KEY[0] = 1'b1;
    #1;
    chk("rst_convst", adc.ADC_CONVST, 0);
    chk("rst_sclk", adc.ADC_SCLK, 0);
    chk("rst_din", adc.ADC_DIN, 0);
    chk("rst_ledr", LEDR, 0);
    chk("rst_gpio_res", GPIO[15:4], 0);
    chk("rst_hex4", HEX4, 7'h40);
    tick();
    tick();
    next_word = 12'h3C6;
    KEY[0] = 1'b0;
    rel_cyc = cyc;
    wait_rise();
    chk("rst_restart_cycle", last_rise - rel_cyc, 1);
    wait_shift_done();
    frame_checks(12'hF80, 0);
    check_outputs(12'h3C6, 3'd7);
    prev_res = 12'h3C6;

    // random frames against the frame-level model
    for (int i = 0; i < 20; i++) begin
      sw   = 10'($urandom);
      word = 12'($urandom);
      k1   = ($urandom_range(0, 3) == 0);
      SW = sw;
      KEY[1] = k1;
      next_word = word;
      wait_rise();
      wait_shift_done();
      frame_checks(exp_din(sw[2:0]), 1);
      expv = k1 ? prev_res : word;
      check_outputs(expv, sw[2:0]);
      prev_res = expv;
    end
    KEY[1] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_ctrl.md
Name: adc_ctrl

Overview:
- Free-running controller for an LTC2308-style 12-bit SPI ADC, clocked from the 50 MHz board clock.
- Each frame it pulses CONVST, then clocks out a 6-bit config word on ADC_DIN while shifting in the 12-bit result on ADC_DOUT.
- The result goes to LEDR, three seven-segment digits and GPIO; the selected channel goes to HEX5.
- Top-level board block, driven directly by pins.

Parameters:
- CLK_DIV, 4: CLOCK_50 cycles per ADC_SCLK period; even, ≥4.
- T_CONV_CYCLES, 80: cycles ADC_CONVST is held high (1.6 µs conversion time).
- FRAME_CYCLES, 200: cycles per conversion frame (250 kS/s). Must be ≥ T_CONV_CYCLES + 12*CLK_DIV + 2.

Ports:
- CLOCK_50 in 1: system clock; all logic is on the rising edge.
- KEY in 4: KEY[0] is the reset, asynchronous and active-high. KEY[1]=1 freezes the displayed result. KEY[3:2] unused.
- SW in 10: SW[2:0] = channel bits {O/S,S1,S0}; SW[9:3] unused.
- LEDR out 10: result[11:2].
- ADC_SCLK out 1: SPI clock.
- ADC_DIN out 1: config bits to ADC, MSB first.
- ADC_DOUT in 1: result bits from ADC, MSB first.
- ADC_CONVST out 1: conversion start.
- HEX5 out 7: channel digit (SW[2:0], 0–7).
- HEX4, HEX3, HEX2 out 7 each: result hex nibbles [11:8], [7:4], [3:0].
- GPIO out 16: {result[11:0], ADC_DOUT, ADC_DIN, ADC_CONVST, ADC_SCLK}, with ADC_SCLK at bit 0.

Behaviour:
- Reset / power-up: every register also carries a power-up initial value equal to its reset value, so the block runs with KEY[0] never asserted.
- Reset values: state=IDLE, counters=0, result=0, SCLK=0, CONVST=0, DIN=0. This gives LEDR=0, GPIO[15:4]=0, HEX4..HEX2 showing "0".
- Config word, sampled from SW at IDLE→CONV: cfg = {1 (single-ended), SW[2], SW[1], SW[0], 1 (unipolar), 0 (no sleep)}.
- Frame counter: counts 0..FRAME_CYCLES-1 and wraps. The FSM is aligned to it.
- IDLE: one cycle after reset, then → CONV.
- CONV: ADC_CONVST=1 for T_CONV_CYCLES cycles, then → SHIFT with CONVST=0.
- SHIFT: 12 SCLK periods, each low CLK_DIV/2 cycles then high CLK_DIV/2 cycles.
  - ADC_DIN shows cfg bit k (MSB first) from the start of SCLK period k; it changes only while SCLK is low. It is 0 after bit 5.
  - ADC_DOUT is sampled on the CLOCK_50 edge where SCLK goes 0→1, MSB first, into a 12-bit shift register.
- SHIFT end: on the cycle after the 12th SCLK high phase ends, result ← shift register unless KEY[1]=1, in which case result holds. Then → WAIT with SCLK=0, DIN=0.
- WAIT: idle until the frame counter wraps, then → CONV (new cfg sampled). ADC_CONVST has no high pulse outside CONV.
- Outputs:
  - Seven-segment outputs are active-low, bit order {g,f,e,d,c,b,a}, hex glyphs 0–F (0=7'h40, 4=7'h19, A=7'h08, F=7'h0E).
  - All digit/LED outputs are combinational decodes of registered values.
- Mid-frame SW change: takes effect at the next frame. The first frame starts 1 cycle after reset release.
- Reset asserted mid-operation: outputs return to reset values immediately; the FSM restarts from IDLE on release.

Decomposition:
- Package adc_pkg: state enum {IDLE,CONV,SHIFT,WAIT}, CFG_BITS=6, RES_BITS=12, seven-segment glyph constants.
- Sub-module hex7seg: 4-bit in, 7-bit active-low out; instantiated 4 times.

Test Plan:
- Power-up with KEY=0, SW=0x0CC, ADC_DOUT=0:
  - CONVST goes high at cycle 1 and stays high for 80 cycles.
  - 12 SCLK pulses follow at 12.5 MHz.
  - DIN bits = 1,1,0,0,1,0.
  - LEDR=0, HEX4..HEX2=7'h40, HEX5=7'h19; the first frame completes within 5 µs.
- ADC model returns 0xA5C: after the frame, LEDR=0x297, HEX4=7'h08 (A), HEX3=7'h12 (5), HEX2=7'h46 (C), GPIO[15:4]=0xA5C.
- SW[2:0] changed mid-SHIFT from 4 to 3: current frame DIN unchanged; next frame DIN = 1,0,1,1,1,0; HEX5 = 7'h30 immediately.
- KEY[1]=1 while ADC returns 0x123 after 0xA5C: result stays 0xA5C; on release the next frame shows 0x123.
- KEY[0] pulsed high mid-SHIFT: CONVST, SCLK, DIN and LEDR go to 0 asynchronously; after release a full frame restarts with CONVST high for 80 cycles.
- Frame period: measure CONVST rising edge to rising edge = 200 cycles (4 µs) over 3 consecutive frames.
